// File: rtl/madgwick_wb_sequencer.sv
// madgwick_wb_sequencer: Wishbone initiator that runs the Madgwick peripheral register sequence for each IMU sample.
// Each transaction is one gap cycle (stb low) followed by an issue phase that lasts until ack or timeout.
module madgwick_wb_sequencer #(
  parameter int ACC_WIDTH   = 16,
  parameter int GYRO_WIDTH  = 16,
  parameter int Q_WIDTH     = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int POLL_MAX    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [5:0]            adr_o,
  output logic [31:0]           dat_o,
  input  logic [31:0]           dat_i,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ACC_WIDTH-1:0]  a_x,
  input  logic [ACC_WIDTH-1:0]  a_y,
  input  logic [ACC_WIDTH-1:0]  a_z,
  input  logic [GYRO_WIDTH-1:0] w_x,
  input  logic [GYRO_WIDTH-1:0] w_y,
  input  logic [GYRO_WIDTH-1:0] w_z,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [Q_WIDTH-1:0]    q_w,
  output logic [Q_WIDTH-1:0]    q_x,
  output logic [Q_WIDTH-1:0]    q_y,
  output logic [Q_WIDTH-1:0]    q_z,
  output logic                  busy,
  output logic                  err_ack,
  output logic                  err_poll
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  typedef enum logic [3:0] {IDLE, INIT, WR_OPS, START, POLL, RD_Q, RELEASE, FIN, OUT} state_e;
  state_e state_q, state_d;
  logic stb_q, stb_d, en_done_q, en_done_d, err_ack_q, err_ack_d, err_poll_q, err_poll_d;
  logic [2:0] idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [ACC_WIDTH-1:0] acc_q [3];
  logic [ACC_WIDTH-1:0] acc_d [3];
  logic [GYRO_WIDTH-1:0] gyr_q [3];
  logic [GYRO_WIDTH-1:0] gyr_d [3];
  logic [Q_WIDTH-1:0] q_q [4];
  logic [Q_WIDTH-1:0] q_d [4];
  logic [31:0] ops [6];
  logic [5:0] adr;
  logic wr;
  logic unused_dat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stb_q      <= 1'b0;
      en_done_q  <= 1'b0;
      err_ack_q  <= 1'b0;
      err_poll_q <= 1'b0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      pcnt_q     <= '0;
      acc_q      <= '{default: '0};
      gyr_q      <= '{default: '0};
      q_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      en_done_q  <= en_done_d;
      err_ack_q  <= err_ack_d;
      err_poll_q <= err_poll_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      pcnt_q     <= pcnt_d;
      acc_q      <= acc_d;
      gyr_q      <= gyr_d;
      q_q        <= q_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    en_done_d  = en_done_q;
    err_ack_d  = err_ack_q;
    err_poll_d = err_poll_q;
    idx_d      = idx_q;
    tcnt_d     = tcnt_q;
    pcnt_d     = pcnt_q;
    acc_d      = acc_q;
    gyr_d      = gyr_q;
    q_d        = q_q;
    case (state_q)
      IDLE: if (s_valid) begin
        acc_d      = '{a_x, a_y, a_z};
        gyr_d      = '{w_x, w_y, w_z};
        err_ack_d  = 1'b0;
        err_poll_d = 1'b0;
        idx_d      = '0;
        state_d    = en_done_q ? WR_OPS : INIT;
      end
      FIN: state_d = err_poll_q ? IDLE : OUT;
      OUT: state_d = q_ready ? IDLE : OUT;
      default: begin
        if (!stb_q) begin
          stb_d  = 1'b1;
          tcnt_d = '0;
        end else if (ack_i) begin
          stb_d = 1'b0;
          case (state_q)
            INIT: begin
              en_done_d = 1'b1;
              idx_d     = '0;
              state_d   = WR_OPS;
            end
            WR_OPS: begin
              state_d = idx_q == 3'd5 ? START : WR_OPS;
              idx_d   = idx_q + 3'd1;
            end
            START: begin
              pcnt_d  = '0;
              state_d = POLL;
            end
            POLL: begin
              if (dat_i[2]) begin
                idx_d   = '0;
                state_d = RD_Q;
              end else if (pcnt_q == PW'(POLL_MAX - 1)) begin
                err_poll_d = 1'b1;
                state_d    = RELEASE;
              end else pcnt_d = pcnt_q + 1'b1;
            end
            RD_Q: begin
              q_d[idx_q[1:0]] = dat_i[Q_WIDTH-1:0];
              state_d         = idx_q == 3'd3 ? RELEASE : RD_Q;
              idx_d           = idx_q + 3'd1;
            end
            RELEASE: state_d = FIN;
            default: state_d = IDLE;
          endcase
        end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
          // Abandon the sample; a peripheral that stopped acking may have lost its enable.
          stb_d     = 1'b0;
          err_ack_d = 1'b1;
          en_done_d = 1'b0;
          state_d   = IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
      end
    endcase
  end
  assign ops = '{32'($signed(acc_q[0])), 32'($signed(acc_q[1])), 32'($signed(acc_q[2])),
                 32'($signed(gyr_q[0])), 32'($signed(gyr_q[1])), 32'($signed(gyr_q[2]))};
  assign adr = state_q == WR_OPS ? {1'b0, idx_q + 3'd1, 2'b00} :
               state_q == RD_Q   ? {4'(idx_q) + 4'd7, 2'b00} : 6'h00;
  assign wr  = state_q != POLL && state_q != RD_Q;
  assign stb_o = stb_q;
  assign cyc_o = stb_q;
  assign we_o  = stb_q && wr;
  assign adr_o = stb_q ? adr : 6'h00;
  assign dat_o = !(stb_q && wr) ? 32'h0 : state_q == WR_OPS ? ops[idx_q] :
                 state_q == START ? 32'h3 : 32'h1;
  assign s_ready  = state_q == IDLE && !rst;
  assign busy     = state_q != IDLE;
  assign q_valid  = state_q == OUT;
  assign q_w      = q_q[0];
  assign q_x      = q_q[1];
  assign q_y      = q_q[2];
  assign q_z      = q_q[3];
  assign err_ack  = err_ack_q;
  assign err_poll = err_poll_q;
  assign unused_dat = ^dat_i;
endmodule

// File: tb/tb_madgwick_wb_sequencer.sv
// tb_madgwick_wb_sequencer: directed bench with a 1-cycle-ack stub slave and a bus transaction log.
module tb_madgwick_wb_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [5:0] adr_o;
  logic [31:0] dat_o, dat_i;
  logic we_o, stb_o, cyc_o, ack_i;
  logic s_valid = 1'b0, s_ready, q_valid, q_ready = 1'b0, busy, err_ack, err_poll;
  logic [15:0] op [6];
  logic [15:0] q_w, q_x, q_y, q_z;
  int errors = 0, checks = 0;
  logic ack_en = 1'b1, done_en = 1'b1;
  int polls_seen = 0;
  logic we_log [512];
  logic [5:0] adr_log [512];
  logic [31:0] dat_log [512];
  int log_n = 0;
  logic exp_we [32];
  logic [5:0] exp_adr [32];
  logic [31:0] exp_dat [32];
  int exp_n = 0;

  madgwick_wb_sequencer #(.POLL_MAX(4)) dut (
    .clk(clk), .rst(rst), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .s_valid(s_valid), .s_ready(s_ready),
    .a_x(op[0]), .a_y(op[1]), .a_z(op[2]), .w_x(op[3]), .w_y(op[4]), .w_z(op[5]),
    .q_valid(q_valid), .q_ready(q_ready), .q_w(q_w), .q_x(q_x), .q_y(q_y), .q_z(q_z),
    .busy(busy), .err_ack(err_ack), .err_poll(err_poll));

  always @(posedge clk or posedge rst)
    if (rst) ack_i <= 1'b0;
    else ack_i <= stb_o && !ack_i && ack_en;
  always @(posedge clk)
    if (stb_o && ack_i && adr_o == 6'h00) polls_seen <= we_o ? 0 : polls_seen + 1;
  always_comb
    case (adr_o)
      6'h00:   dat_i = {29'd0, done_en && polls_seen >= 1, 2'b11};
      6'h1C:   dat_i = 32'hABCD4000;
      6'h20:   dat_i = 32'h55AA0001;
      6'h24:   dat_i = 32'h00000002;
      6'h28:   dat_i = 32'hFFFF0003;
      default: dat_i = 32'hDEADBEEF;
    endcase
  always @(negedge clk)
    if (stb_o && ack_i && log_n < 512) begin
      we_log[log_n]  = we_o;
      adr_log[log_n] = adr_o;
      dat_log[log_n] = we_o ? dat_o : dat_i;
      log_n = log_n + 1;
    end

  task automatic push(input logic w, input logic [5:0] a, input logic [31:0] d);
    exp_we[exp_n] = w; exp_adr[exp_n] = a; exp_dat[exp_n] = d; exp_n++;
  endtask
  task automatic build_exp(input bit init, input int polls, input bit reads);
    exp_n = 0;
    if (init) push(1'b1, 6'h00, 32'h1);
    for (int i = 0; i < 6; i++) push(1'b1, 6'(4 + 4 * i), {{16{op[i][15]}}, op[i]});
    push(1'b1, 6'h00, 32'h3);
    for (int i = 0; i < polls; i++) push(1'b0, 6'h00, 32'h0);
    if (reads) for (int i = 0; i < 4; i++) push(1'b0, 6'(28 + 4 * i), 32'h0);
    push(1'b1, 6'h00, 32'h1);
  endtask
  task automatic send_sample();
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin checks++; errors++; $display("FAIL s_ready_wait: s_ready=%b required 1", s_ready); end
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask
  task automatic wait_q(output int lat);
    lat = 0;
    while (!q_valid && lat < 400) begin @(negedge clk); lat++; end
  endtask
  task automatic release_q();
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({stb_o, cyc_o, we_o, adr_o, dat_o, s_ready, q_valid, q_w, q_x, q_y, q_z, busy, err_ack, err_poll} !== '0) begin
      errors++; $display("FAIL reset_outputs: stb=%b s_ready=%b busy=%b q_valid=%b required all 0", stb_o, s_ready, busy, q_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, busy, stb_o} !== 3'b100) begin
      errors++; $display("FAIL reset_idle: s_ready/busy/stb=%b required 100", {s_ready, busy, stb_o});
    end
  endtask

  task automatic test_first_sample();
    int lat, base;
    op = '{16'h0100, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h0005, 16'hF000};
    base = log_n;
    send_sample();
    wait_q(lat);
    checks++;
    if (lat !== 46) begin errors++; $display("FAIL first_latency: got %0d required 46", lat); end
    build_exp(1'b1, 2, 1'b1);
    checks++;
    if (log_n - base !== exp_n) begin errors++; $display("FAIL first_log_len: got %0d required %0d", log_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      checks++;
      if (we_log[base+k] !== exp_we[k] || adr_log[base+k] !== exp_adr[k] || (exp_we[k] && dat_log[base+k] !== exp_dat[k])) begin
        errors++; $display("FAIL first_log[%0d]: got we=%b adr=%h dat=%h required we=%b adr=%h dat=%h", k,
                           we_log[base+k], adr_log[base+k], dat_log[base+k], exp_we[k], exp_adr[k], exp_dat[k]);
      end
    end
    checks++;
    if ({q_w, q_x, q_y, q_z} !== 64'h4000_0001_0002_0003) begin
      errors++; $display("FAIL first_q: got %h %h %h %h required 4000 0001 0002 0003", q_w, q_x, q_y, q_z);
    end
    release_q();
  endtask

  task automatic test_no_init();
    int lat, base;
    op = '{16'h1234, 16'h0001, 16'hFF00, 16'h8001, 16'h0000, 16'h00FF};
    base = log_n;
    send_sample();
    wait_q(lat);
    checks++;
    if (lat !== 43) begin errors++; $display("FAIL noinit_latency: got %0d required 43", lat); end
    build_exp(1'b0, 2, 1'b1);
    checks++;
    if (log_n - base !== exp_n) begin errors++; $display("FAIL noinit_log_len: got %0d required %0d", log_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      checks++;
      if (we_log[base+k] !== exp_we[k] || adr_log[base+k] !== exp_adr[k] || (exp_we[k] && dat_log[base+k] !== exp_dat[k])) begin
        errors++; $display("FAIL noinit_log[%0d]: got we=%b adr=%h dat=%h required we=%b adr=%h dat=%h", k,
                           we_log[base+k], adr_log[base+k], dat_log[base+k], exp_we[k], exp_adr[k], exp_dat[k]);
      end
    end
    release_q();
  endtask

  task automatic test_hold();
    int lat;
    send_sample();
    wait_q(lat);
    checks++;
    if (lat !== 43) begin errors++; $display("FAIL hold_latency: got %0d required 43", lat); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({q_valid, s_ready, busy} !== 3'b101 || {q_w, q_x, q_y, q_z} !== 64'h4000_0001_0002_0003) begin
        errors++; $display("FAIL hold_cycle%0d: q_valid/s_ready/busy=%b q=%h%h%h%h required 101 4000000100020003", c,
                           {q_valid, s_ready, busy}, q_w, q_x, q_y, q_z);
      end
    end
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    checks++;
    if ({q_valid, s_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL hold_release: q_valid/s_ready/busy=%b required 010", {q_valid, s_ready, busy});
    end
  endtask

  task automatic test_ack_timeout();
    int hi = 0, n = 0, lat, base;
    ack_en = 1'b0;
    send_sample();
    while (n < 300) begin
      if (stb_o) hi++;
      else if (hi > 0) break;
      @(negedge clk);
      n++;
    end
    checks++;
    if (hi !== 64) begin errors++; $display("FAIL ack_timeout_len: stb high %0d cycles required 64", hi); end
    checks++;
    if ({err_ack, s_ready, busy, q_valid, cyc_o} !== 5'b11000) begin
      errors++; $display("FAIL ack_timeout_state: err_ack/s_ready/busy/q_valid/cyc=%b required 11000",
                         {err_ack, s_ready, busy, q_valid, cyc_o});
    end
    ack_en = 1'b1;
    base = log_n;
    send_sample();
    checks++;
    if (err_ack !== 1'b0) begin errors++; $display("FAIL ack_err_clear: err_ack=%b required 0", err_ack); end
    wait_q(lat);
    checks++;
    if (lat !== 46) begin errors++; $display("FAIL ack_recover_latency: got %0d required 46", lat); end
    checks++;
    if (we_log[base] !== 1'b1 || adr_log[base] !== 6'h00 || dat_log[base] !== 32'h1) begin
      errors++; $display("FAIL ack_recover_init: got we=%b adr=%h dat=%h required we=1 adr=00 dat=00000001",
                         we_log[base], adr_log[base], dat_log[base]);
    end
    release_q();
  endtask

  task automatic test_poll_timeout();
    int n = 0, base;
    bit saw = 1'b0;
    done_en = 1'b0;
    op = '{16'h0007, 16'h0008, 16'h0009, 16'hFFF0, 16'hFFF1, 16'hFFF2};
    base = log_n;
    send_sample();
    while (busy && n < 300) begin
      if (q_valid) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || saw) begin errors++; $display("FAIL poll_end: busy=%b saw_q_valid=%b required 0 0", busy, saw); end
    build_exp(1'b0, 4, 1'b0);
    checks++;
    if (log_n - base !== exp_n) begin errors++; $display("FAIL poll_log_len: got %0d required %0d", log_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      checks++;
      if (we_log[base+k] !== exp_we[k] || adr_log[base+k] !== exp_adr[k] || (exp_we[k] && dat_log[base+k] !== exp_dat[k])) begin
        errors++; $display("FAIL poll_log[%0d]: got we=%b adr=%h dat=%h required we=%b adr=%h dat=%h", k,
                           we_log[base+k], adr_log[base+k], dat_log[base+k], exp_we[k], exp_adr[k], exp_dat[k]);
      end
    end
    checks++;
    if ({err_poll, err_ack, s_ready} !== 3'b101) begin
      errors++; $display("FAIL poll_flags: err_poll/err_ack/s_ready=%b required 101", {err_poll, err_ack, s_ready});
    end
    done_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0, lat, base;
    send_sample();
    while (!(stb_o && adr_o == 6'h20) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!(stb_o && adr_o == 6'h20)) begin errors++; $display("FAIL rst_r20_wait: stb=%b adr=%h required 1 20", stb_o, adr_o); end
    rst = 1'b1;
    #1;
    checks++;
    if ({stb_o, cyc_o, we_o, adr_o, dat_o, s_ready, q_valid, q_w, q_x, q_y, q_z, busy, err_ack, err_poll} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: stb=%b cyc=%b busy=%b q_w=%h err_poll=%b required all 0",
                         stb_o, cyc_o, busy, q_w, err_poll);
    end
    @(negedge clk);
    rst = 1'b0;
    base = log_n;
    send_sample();
    wait_q(lat);
    checks++;
    if (lat !== 46) begin errors++; $display("FAIL rst_rerun_latency: got %0d required 46", lat); end
    checks++;
    if (we_log[base] !== 1'b1 || adr_log[base] !== 6'h00 || dat_log[base] !== 32'h1) begin
      errors++; $display("FAIL rst_rerun_init: got we=%b adr=%h dat=%h required we=1 adr=00 dat=00000001",
                         we_log[base], adr_log[base], dat_log[base]);
    end
    release_q();
  endtask

  initial begin
    op = '{default: 16'h0};
    test_reset();
    test_first_sample();
    test_no_init();
    test_hold();
    test_ack_timeout();
    test_poll_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/madgwick_wb_sequencer.md
# madgwick_wb_sequencer

Wishbone initiator that drives the attitude-sensor Madgwick peripheral on behalf of a hardware sample source, so the CPU does not have to. It takes one IMU sample through a valid/ready handshake and runs the full register sequence over Wishbone: write the operands, start, poll done, read the quaternion, then release start. It returns the quaternion on a valid/ready output. It sits between the IMU front-end and the Madgwick peripheral's Wishbone slave port, or on a shared bus segment with it.

## Interface
- ACC_WIDTH, 16: accel operand width; driven sign-extended to 32 bits on `dat_o`.
- GYRO_WIDTH, 16: gyro operand width; driven sign-extended to 32 bits on `dat_o`.
- Q_WIDTH, 16: quaternion component width; taken from `dat_i[Q_WIDTH-1:0]`.
- ACK_TIMEOUT, 64: maximum number of cycles `stb_o` may wait for `ack_i`.
- POLL_MAX, 1024: maximum number of control-register polls before the block declares a timeout.
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- adr_o  out  6  Wishbone address.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data.
- we_o  out  1  Wishbone write enable.
- stb_o  out  1  Wishbone strobe.
- cyc_o  out  1  Wishbone cycle; always equal to `stb_o`.
- ack_i  in  1  Wishbone acknowledge.
- s_valid  in  1  a sample is available.
- s_ready  out  1  the block can accept a sample.
- a_x, a_y, a_z  in  ACC_WIDTH each  accelerometer sample.
- w_x, w_y, w_z  in  GYRO_WIDTH each  gyroscope sample.
- q_valid  out  1  the quaternion outputs are valid.
- q_ready  in  1  the consumer accepts the quaternion.
- q_w, q_x, q_y, q_z  out  Q_WIDTH each  quaternion result.
- busy  out  1  a sequence is in progress.
- err_ack  out  1  sticky flag: an ack timeout occurred.
- err_poll  out  1  sticky flag: a poll timeout occurred.

## Operation
- Peripheral register map:
  - 0x00 CTRL: bit0 enable, bit1 start; bit2 done, read-only.
  - 0x04, 0x08, 0x0C: a_x, a_y, a_z.
  - 0x10, 0x14, 0x18: w_x, w_y, w_z.
  - 0x1C, 0x20, 0x24, 0x28: q_w, q_x, q_y, q_z, read-only.
- Sample capture: `s_ready` = 1 only in IDLE. On `s_valid && s_ready` the block latches all six operands, clears `err_ack` and `err_poll`, and leaves IDLE.
- States and transaction order:
  - IDLE.
  - INIT: write CTRL=0x1. Issued only while the internal `en_done` flag is 0; `en_done` is set after this write and cleared by reset.
  - WR_OPS: six writes to 0x04..0x18, in ascending address order.
  - START: write CTRL=0x3.
  - POLL: read CTRL; repeat until `dat_i[2]`=1.
  - RD_Q: four reads from 0x1C..0x28; `dat_i` is captured into q_w..q_z.
  - RELEASE: write CTRL=0x1.
  - OUT: `q_valid`=1, held until `q_ready`; then return to IDLE.
- Every transaction uses the same bus states:
  - ISSUE: `stb_o` and `cyc_o` high; `adr_o`, `we_o`, `dat_o` stable.
  - On the edge where `ack_i`=1: drop `stb_o`/`cyc_o`, capture read data, and spend exactly one GAP cycle with `stb_o`=0 before the next ISSUE.
  - The GAP cycle is mandatory, because the slave re-acknowledges if the strobe is held across its ack.
- `ack_i` seen while `stb_o`=0 is ignored.
- `busy` = 1 in every state except IDLE.
- Ack timeout: `stb_o` high for ACK_TIMEOUT cycles without `ack_i` →
  - drop `stb_o`/`cyc_o`;
  - set `err_ack` and clear `en_done`;
  - go to IDLE without asserting `q_valid`.
- Poll timeout: POLL_MAX polls complete without done →
  - set `err_poll`;
  - issue the RELEASE write;
  - go to IDLE without asserting `q_valid`.
- The q_w..q_z outputs keep their last value until the next RD_Q overwrites them.

## Timing
- Reset values: every output 0 (`s_ready` becomes 1 the first cycle after reset deasserts, in IDLE); `en_done`=0.
- Asserting `rst` mid-transaction drops `stb_o`/`cyc_o` asynchronously. The next sample re-runs INIT.
- Each transaction with a 1-cycle ack slave takes 3 cycles: 2 with `stb_o` high, then 1 GAP.
- Latency from sample accept to `q_valid`:
  - 3·(12+P) + 1 cycles, where P ≥ 1 is the number of polls;
  - plus 3 cycles when INIT runs.
- Handshake back-to-back case: if `q_ready` is high while `q_valid` is high, the block reaches IDLE on the next edge, and `s_ready` is 1 in the following cycle.

## Test plan
- Stub slave with 1-cycle ack, done set after 2 polls, returning q_w=0x4000, q_x=0x0001, q_y=0x0002, q_z=0x0003:
  - send the first sample a_x=0x0100 → bus log reads W00=1, W04..W18 carrying sign-extended operands, W00=3, R00×2, R1C..R28, W00=1;
  - `q_valid` rises 46 cycles after accept, with the matching q values.
- Second sample on the same stub → no INIT write; `q_valid` 43 cycles after accept.
- Slave never acks → `stb_o` drops after 64 cycles, `err_ack`=1, `s_ready`=1; the next sample re-issues W00=1 and clears `err_ack`.
- Done never sets, with POLL_MAX=4 → exactly 4 R00 reads, then W00=1, `err_poll`=1, no `q_valid`.
- Hold `q_ready`=0 for 10 cycles → `q_valid` and the q values stay stable and `s_ready`=0; `q_ready` pulse → IDLE next cycle.
- Assert `rst` during an R20 strobe → `stb_o`/`cyc_o` go to 0 immediately and all outputs clear; the next sample starts with INIT.
